// File: rtl/vram_rect_writer_pkg.sv
// Shared constants, types and the frame-buffer address mapping for vram_rect_writer.
// The mapping is bottom-up: row y=0 sits at the top of the address space.
package vram_rect_writer_pkg;

    localparam int WIDTH  = 640;
    localparam int HEIGHT = 480;
    localparam int AW     = 19;
    localparam int CW     = 12;
    localparam int XYW    = 10;

    typedef logic [XYW-1:0] coord_t;
    typedef logic [AW-1:0]  addr_t;
    typedef logic [CW-1:0]  color_t;

    typedef enum logic [1:0] {IDLE, SETUP, FILL} state_t;

    typedef struct packed {
        coord_t x0;
        coord_t y0;
        coord_t x1;
        coord_t y1;
        color_t color;
    } rect_cmd_t;

    function automatic addr_t addr_of(input coord_t x, input coord_t y);
        return addr_t'(WIDTH * (HEIGHT - 1 - int'(y)) + int'(x));
    endfunction

endpackage

// File: rtl/vram_rect_writer_if.sv
// Command handshake, status and frame-buffer write bus of vram_rect_writer.
// master = command source / frame-buffer side, slave = the rectangle engine.
interface vram_rect_writer_if;
    import vram_rect_writer_pkg::*;

    logic   cmd_valid;
    logic   cmd_ready;
    coord_t cmd_x0;
    coord_t cmd_y0;
    coord_t cmd_x1;
    coord_t cmd_y1;
    color_t cmd_color;
    logic   busy;
    logic   done;
    logic   err;
    addr_t  WAddr;
    color_t Din;
    logic   WE;

    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
        input  cmd_ready, busy, done, err, WAddr, Din, WE
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
        output cmd_ready, busy, done, err, WAddr, Din, WE
    );

endinterface

// File: rtl/vram_rect_writer_rect_addr_gen.sv
// Raster address walker for one rectangle: x runs xl..xr, rows run yl..yh,
// each new row reloads from row_base minus one frame row.
module rect_addr_gen
    import vram_rect_writer_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   start,
    input  coord_t xl,
    input  coord_t xr,
    input  coord_t yl,
    input  coord_t yh,
    output addr_t  addr,
    output logic   valid,
    output logic   last
);

    coord_t x_q;
    coord_t y_q;
    coord_t xl_q;
    coord_t xr_q;
    coord_t yh_q;
    addr_t  row_base_q;
    addr_t  first_addr;
    logic   row_end;

    // The single multiply of a command; its result is registered straight into addr.
    assign first_addr = addr_of(xl, yl);
    assign row_end    = (x_q == xr_q);
    assign last       = valid && row_end && (y_q == yh_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            addr  <= '0;
        end else if (start) begin
            valid <= 1'b1;
            addr  <= first_addr;
        end else if (valid) begin
            if (last) begin
                valid <= 1'b0;
            end else if (row_end) begin
                addr <= row_base_q - addr_t'(WIDTH);
            end else begin
                addr <= addr + addr_t'(1);
            end
        end
    end

    // NOTE: pure datapath registers carry no reset; valid gates every use of them.
    always_ff @(posedge clk) begin
        if (start) begin
            x_q        <= xl;
            y_q        <= yl;
            xl_q       <= xl;
            xr_q       <= xr;
            yh_q       <= yh;
            row_base_q <= first_addr;
        end else if (valid && !last && row_end) begin
            x_q        <= xl_q;
            y_q        <= y_q + coord_t'(1);
            row_base_q <= row_base_q - addr_t'(WIDTH);
        end else if (valid && !last) begin
            x_q <= x_q + coord_t'(1);
        end
    end

endmodule

// File: rtl/vram_rect_writer.sv
// Filled-rectangle write engine for the 640x480x12 frame buffer.
// Define VRAM_RECT_CLIP_EN to clip the far corner instead of rejecting oversize commands.
module vram_rect_writer
    import vram_rect_writer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    vram_rect_writer_if.slave bus
);

    state_t    state_q;
    state_t    state_d;
    rect_cmd_t cmd_q;
    logic      ready_q;
    logic      busy_q;
    logic      done_q;
    logic      err_q;
    color_t    din_q;

    coord_t    xl;
    coord_t    xr;
    coord_t    yl;
    coord_t    yh;
    logic      reject;
    logic      start;
    logic      handshake;

    addr_t     gen_addr;
    logic      gen_valid;
    logic      gen_last;

    assign handshake = (state_q == IDLE) && bus.cmd_valid && ready_q;

    // NOTE: combinational blocks use blocking assignments and set every output first, so no latch appears.
    always_comb begin
        xl = (cmd_q.x0 < cmd_q.x1) ? cmd_q.x0 : cmd_q.x1;
        xr = (cmd_q.x0 < cmd_q.x1) ? cmd_q.x1 : cmd_q.x0;
        yl = (cmd_q.y0 < cmd_q.y1) ? cmd_q.y0 : cmd_q.y1;
        yh = (cmd_q.y0 < cmd_q.y1) ? cmd_q.y1 : cmd_q.y0;
`ifdef VRAM_RECT_CLIP_EN
        reject = (xl >= coord_t'(WIDTH)) || (yl >= coord_t'(HEIGHT));
        if (xr > coord_t'(WIDTH - 1))  xr = coord_t'(WIDTH - 1);
        if (yh > coord_t'(HEIGHT - 1)) yh = coord_t'(HEIGHT - 1);
`else
        reject = (xr >= coord_t'(WIDTH)) || (yh >= coord_t'(HEIGHT));
`endif
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE:  if (handshake) state_d = SETUP;
            SETUP: begin
                if (reject) begin
                    state_d = IDLE;
                end else begin
                    state_d = FILL;
                    start   = 1'b1;
                end
            end
            FILL:  if (gen_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_q == FILL) && gen_last;
            err_q   <= (state_q == SETUP) && reject;
            if (start) din_q <= cmd_q.color;
        end
    end

    // The source holds its command until accepted, so only the handshake loads it.
    always_ff @(posedge clk) begin
        if (handshake) begin
            cmd_q <= '{x0: bus.cmd_x0, y0: bus.cmd_y0, x1: bus.cmd_x1,
                       y1: bus.cmd_y1, color: bus.cmd_color};
        end
    end

    rect_addr_gen u_addr_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .xl    (xl),
        .xr    (xr),
        .yl    (yl),
        .yh    (yh),
        .addr  (gen_addr),
        .valid (gen_valid),
        .last  (gen_last)
    );

    assign bus.cmd_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.WAddr     = gen_addr;
    assign bus.Din       = din_q;
    assign bus.WE        = gen_valid;

endmodule

// File: tb/tb_vram_rect_writer.sv
// Self-checking bench for vram_rect_writer; expected writes come from a raster model.
// Honours VRAM_RECT_CLIP_EN the same way as the design build.
module tb_vram_rect_writer;
    import vram_rect_writer_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vram_rect_writer_if bus();

    vram_rect_writer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: everything the engine does, sampled mid-cycle.
    int unsigned mq_addr[$];
    int unsigned mq_data[$];
    int first_cyc, last_cyc, done_cnt, err_cnt, done_cyc, err_cyc, hs_cyc, ready_at_done;

    always @(negedge clk) begin
        if (bus.cmd_valid && bus.cmd_ready) hs_cyc = cyc;
        if (bus.WE) begin
            if (mq_addr.size() == 0) first_cyc = cyc;
            last_cyc = cyc;
            mq_addr.push_back(int'(bus.WAddr));
            mq_data.push_back(int'(bus.Din));
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc      = cyc;
            ready_at_done = int'(bus.cmd_ready);
        end
        if (bus.err) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        mq_addr.delete();
        mq_data.delete();
        first_cyc     = -1;
        last_cyc      = -1;
        done_cnt      = 0;
        err_cnt       = 0;
        done_cyc      = -1;
        err_cyc       = -1;
        ready_at_done = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the handshake.
    task automatic send(input string tag, input int x0, input int y0, input int x1, input int y1,
                        input int col);
        bit ok = 1'b0;
        bus.cmd_x0    = coord_t'(x0);
        bus.cmd_y0    = coord_t'(y0);
        bus.cmd_x1    = coord_t'(x1);
        bus.cmd_y1    = coord_t'(y1);
        bus.cmd_color = color_t'(col);
        bus.cmd_valid = 1'b1;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        check({tag, ":accepted"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (done_cnt == 0 && err_cnt == 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        check({tag, ":timeout"}, 32'(done_cnt == 0 && err_cnt == 0), 32'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Reference model: the frame is a 640-wide raster stored bottom row first.
    task automatic verify(input string tag, input int x0, input int y0, input int x1, input int y1,
                          input int col);
        int xl = (x0 < x1) ? x0 : x1;
        int xr = (x0 < x1) ? x1 : x0;
        int yl = (y0 < y1) ? y0 : y1;
        int yh = (y0 < y1) ? y1 : y0;
        bit rej;
        int unsigned exp_q[$];
        int bad_addr = 0;
        int bad_data = 0;
`ifdef VRAM_RECT_CLIP_EN
        rej = (xl >= 640) || (yl >= 480);
        if (xr > 639) xr = 639;
        if (yh > 479) yh = 479;
`else
        rej = (xr >= 640) || (yh >= 480);
`endif
        if (rej) begin
            check({tag, ":err_cnt"}, err_cnt, 1);
            check({tag, ":writes"}, mq_addr.size(), 0);
            check({tag, ":done_cnt"}, done_cnt, 0);
            check({tag, ":err_cycle"}, err_cyc, hs_cyc + 2);
        end else begin
            for (int y = yl; y <= yh; y++)
                for (int x = xl; x <= xr; x++)
                    exp_q.push_back(int'(640 * (479 - y) + x));
            check({tag, ":writes"}, mq_addr.size(), exp_q.size());
            for (int i = 0; i < mq_addr.size() && i < exp_q.size(); i++) begin
                if (mq_addr[i] != exp_q[i]) bad_addr++;
                if (mq_data[i] != col)      bad_data++;
            end
            check({tag, ":addr_seq"}, bad_addr, 0);
            check({tag, ":data_seq"}, bad_data, 0);
            check({tag, ":first_addr"}, (mq_addr.size() > 0) ? mq_addr[0] : 32'hFFFF_FFFF, exp_q[0]);
            check({tag, ":last_addr"}, (mq_addr.size() > 0) ? mq_addr[$] : 32'hFFFF_FFFF, exp_q[$]);
            check({tag, ":first_we_lat"}, first_cyc, hs_cyc + 2);
            check({tag, ":no_gaps"}, last_cyc - first_cyc + 1, exp_q.size());
            check({tag, ":done_cnt"}, done_cnt, 1);
            check({tag, ":done_cycle"}, done_cyc, last_cyc + 1);
            check({tag, ":ready_at_done"}, ready_at_done, 1);
            check({tag, ":err_cnt"}, err_cnt, 0);
        end
    endtask

    task automatic run_cmd(input string tag, input int x0, input int y0, input int x1, input int y1,
                           input int col);
        clear_mon();
        send(tag, x0, y0, x1, y1, col);
        wait_end(tag);
        verify(tag, x0, y0, x1, y1, col);
    endtask

    initial begin
        int rx0, ry0, rx1, ry1;
        bus.cmd_valid = 1'b0;
        bus.cmd_x0    = '0;
        bus.cmd_y0    = '0;
        bus.cmd_x1    = '0;
        bus.cmd_y1    = '0;
        bus.cmd_color = '0;
        clear_mon();
        hs_cyc = -1;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset:cmd_ready", bus.cmd_ready, 0);
        check("reset:busy", bus.busy, 0);
        check("reset:done", bus.done, 0);
        check("reset:err", bus.err, 0);
        check("reset:WE", bus.WE, 0);
        check("reset:WAddr", bus.WAddr, 0);
        check("reset:Din", bus.Din, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release:cmd_ready", bus.cmd_ready, 1);

        run_cmd("single", 0, 0, 0, 0, 'hF00);
        check("single:addr306560", (mq_addr.size() > 0) ? mq_addr[0] : 0, 306560);
        run_cmd("small", 10, 5, 12, 6, 'h0F0);
        check("small:addr303370", (mq_addr.size() > 0) ? mq_addr[0] : 0, 303370);
        check("small:addr302730", (mq_addr.size() > 3) ? mq_addr[3] : 0, 302730);
        run_cmd("swapped", 12, 6, 10, 5, 'h0F0);
        run_cmd("wide", 0, 0, 639, 20, 'h00F);
        run_cmd("corner", 600, 470, 639, 479, 'h5A5);
        run_cmd("x1_700", 630, 0, 700, 2, 'h123);
        run_cmd("yl_oob", 5, 500, 6, 501, 'h456);
        run_cmd("xl_oob", 650, 10, 660, 12, 'h789);

        // Second command offered during the first fill is only taken on the done cycle.
        clear_mon();
        send("b2b_a", 10, 5, 12, 6, 'hABC);
        send("b2b_b", 20, 30, 21, 31, 'hDEF);
        check("b2b:hs_at_done", hs_cyc, done_cyc);
        check("b2b:a_writes", mq_addr.size(), 6);
        check("b2b:a_first", (mq_addr.size() > 0) ? mq_addr[0] : 0, 303370);
        clear_mon();
        wait_end("b2b_b");
        verify("b2b_b", 20, 30, 21, 31, 'hDEF);

        // Reset asserted during the third write of a 3x2 fill.
        clear_mon();
        send("rst_fill", 10, 5, 12, 6, 'h0F0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_fill:WE", bus.WE, 0);
        check("rst_fill:busy", bus.busy, 0);
        check("rst_fill:cmd_ready", bus.cmd_ready, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_fill:ready_after", bus.cmd_ready, 1);
        repeat (6) @(posedge clk);
        #1;
        check("rst_fill:writes", mq_addr.size(), 3);
        check("rst_fill:done_cnt", done_cnt, 0);
        run_cmd("after_rst", 100, 200, 104, 203, 'hC3C);

        for (int i = 0; i < 6; i++) begin
            rx0 = int'($urandom_range(0, 639));
            ry0 = int'($urandom_range(0, 479));
            rx1 = rx0 + int'($urandom_range(0, 15));
            ry1 = ry0 + int'($urandom_range(0, 7));
            if (rx1 > 639) rx1 = 639;
            if (ry1 > 479) ry1 = 479;
            if ($urandom_range(0, 1) == 1) run_cmd("rand", rx1, ry0, rx0, ry1, int'($urandom_range(0, 4095)));
            else                           run_cmd("rand", rx0, ry1, rx1, ry0, int'($urandom_range(0, 4095)));
        end
        rx0 = int'($urandom_range(620, 639));
        ry0 = int'($urandom_range(0, 470));
        run_cmd("rand_oob", rx0, ry0, int'($urandom_range(640, 1023)), ry0 + 2, int'($urandom_range(0, 4095)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
